// File: rtl/cond_br_rr_pkg.sv
// rtl/cond_br_rr_pkg.sv - shared types and constants for the round-robin conditional-branch arbiter
package cond_br_rr_pkg;

    // One-slot buffer occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Width of the optional fire counters.
    localparam int CNT_W = 32;

    // Index width.
    // Never returns zero, so a bus is always at least one bit wide.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cond_br_rr_arbiter_rr_pick.sv
// rtl/cond_br_rr_arbiter_rr_pick.sv - combinational round-robin selector
//
// Returns the first eligible index at or after rr_ptr, scanning upward and
// wrapping modulo NUM_REQ.
//
// Ports:
//   elig    in  NUM_REQ  eligible requesters
//   rr_ptr  in  IDX_W    highest-priority index this cycle
//   any     out 1        at least one requester is eligible
//   w       out IDX_W    winning index (0 when any = 0)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any,
    output logic [IDX_W-1:0]   w
);

    logic [IDX_W-1:0] idx_t;

    // Scan from the lowest priority (offset NUM_REQ-1) down to offset 0.
    // A later hit overwrites an earlier one, so the nearest eligible index
    // at or after rr_ptr wins.
    always_comb begin
        any   = 1'b0;
        w     = '0;
        idx_t = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_t = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (elig[idx_t]) begin
                any = 1'b1;
                w   = idx_t;
            end
        end
    end

endmodule

// File: rtl/cond_br_rr_arbiter.sv
// rtl/cond_br_rr_arbiter.sv - round-robin arbiter feeding a buffered conditional branch
//
// Optional feature macro: COND_BR_RR_STATS_EN (adds the true_count and false_count outputs).
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   ins / ins_valid / ins_ready
//                            per-requester data channels (packed, DATA_TYPE bits each)
//   conds / conds_valid / conds_ready
//                            per-requester condition channels
//   trueOut*                 buffered token when the condition is 1, tagged with its requester index
//   falseOut*                buffered token when the condition is 0, tagged with its requester index
//   true_count, false_count  fire counters (only when COND_BR_RR_STATS_EN is defined)
module cond_br_rr_arbiter
    import cond_br_rr_pkg::*;
#(
    parameter  int DATA_TYPE = 32,
    parameter  int NUM_REQ   = 4,
    localparam int IDX_W     = clog2_min1(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*DATA_TYPE-1:0] ins,
    input  logic [NUM_REQ-1:0]           ins_valid,
    output logic [NUM_REQ-1:0]           ins_ready,
    input  logic [NUM_REQ-1:0]           conds,
    input  logic [NUM_REQ-1:0]           conds_valid,
    output logic [NUM_REQ-1:0]           conds_ready,
    output logic [DATA_TYPE-1:0]         trueOut,
    output logic [IDX_W-1:0]             trueOut_index,
    output logic                         trueOut_valid,
    input  logic                         trueOut_ready,
    output logic [DATA_TYPE-1:0]         falseOut,
    output logic [IDX_W-1:0]             falseOut_index,
    output logic                         falseOut_valid,
    input  logic                         falseOut_ready
`ifdef COND_BR_RR_STATS_EN
    ,
    output logic [CNT_W-1:0]             true_count,
    output logic [CNT_W-1:0]             false_count
`endif
);

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [DATA_TYPE-1:0] data_q;
    logic                 cond_q;
    logic [IDX_W-1:0]     idx_q;

    logic [NUM_REQ-1:0]   elig;
    logic                 any;
    logic [IDX_W-1:0]     w;
    logic                 fire;
    logic                 take;
    logic [IDX_W-1:0]     rr_next;

    assign elig = ins_valid & conds_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .elig   (elig),
        .rr_ptr (rr_ptr),
        .any    (any),
        .w      (w)
    );

    // Only the ready of the selected direction matters.
    assign fire = (state == FULL) & (cond_q ? trueOut_ready : falseOut_ready);

    // Accept a new token into an empty slot, or into a slot draining this cycle.
    // In EMPTY, fire is 0, so the output readies cannot reach ins_ready.
    assign take    = any & ((state == EMPTY) | fire);
    assign rr_next = (w == IDX_W'(NUM_REQ - 1)) ? '0 : w + 1'b1;

    // One-hot grant to the winner only; rst blocks it so nothing is consumed during reset.
    always_comb begin
        ins_ready = '0;
        if (take && !rst) begin
            ins_ready[w] = 1'b1;
        end
    end
    assign conds_ready = ins_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            rr_ptr <= '0;
            data_q <= '0;
            cond_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            if (take) begin
                data_q <= ins[int'(w)*DATA_TYPE +: DATA_TYPE];
                cond_q <= conds[w];
                idx_q  <= w;
                rr_ptr <= rr_next;
                state  <= FULL;
            end else if (fire) begin
                state  <= EMPTY;
            end
        end
    end

    assign trueOut_valid  = (state == FULL) &  cond_q;
    assign falseOut_valid = (state == FULL) & ~cond_q;
    assign trueOut        = data_q;
    assign falseOut       = data_q;
    assign trueOut_index  = idx_q;
    assign falseOut_index = idx_q;

`ifdef COND_BR_RR_STATS_EN
    // Both counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            true_count  <= '0;
            false_count <= '0;
        end else if (fire) begin
            if (cond_q) begin
                true_count  <= true_count + 1'b1;
            end else begin
                false_count <= false_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/cond_br_rr_arbiter.md
Name: cond_br_rr_arbiter

Overview:
- Shares one conditional-branch datapath among NUM_REQ requesters. Each requester presents a data channel and a condition channel.
- Arbitrates round-robin over requesters whose data and condition are both valid, and buffers the winner in a one-slot register.
- Steers the buffered token to the true or false output, tagged with the winner's index.
- Used where several loop bodies funnel into a single steering point to save area.

Parameters:
- DATA_TYPE, 32, data width in bits
- NUM_REQ, 4, number of requesters (2..16)
- IDX_W, $clog2(NUM_REQ), width of the index tag (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ins  in  NUM_REQ*DATA_TYPE  packed data; requester i occupies bits [i*DATA_TYPE +: DATA_TYPE]
- ins_valid  in  NUM_REQ  data valid, one bit per requester
- ins_ready  out  NUM_REQ  data ready, one bit per requester
- conds  in  NUM_REQ  condition bit per requester
- conds_valid  in  NUM_REQ  condition valid
- conds_ready  out  NUM_REQ  condition ready
- trueOut  out  DATA_TYPE  buffered data, true output
- trueOut_index  out  IDX_W  requester tag on the true output
- trueOut_valid  out  1
- trueOut_ready  in  1
- falseOut  out  DATA_TYPE  buffered data, false output
- falseOut_index  out  IDX_W  requester tag on the false output
- falseOut_valid  out  1
- falseOut_ready  in  1

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. On rst:
  - state = EMPTY, rr_ptr = 0
  - data, cond and index registers = 0
  - all *_valid and *_ready outputs = 0
- Eligibility: elig[i] = ins_valid[i] & conds_valid[i].
- Grant selection: the winner is the first eligible index at or after rr_ptr, scanning upward and wrapping modulo NUM_REQ.
- The selection is combinational from elig and rr_ptr.
- State EMPTY:
  - If any elig: assert ins_ready[w] and conds_ready[w] for the winner w only, in the same cycle.
  - Capture data/cond/w on the clock edge, set rr_ptr = (w+1) mod NUM_REQ, and go to FULL.
  - Otherwise hold state; all ready outputs = 0.
- State FULL:
  - trueOut_valid = cond_q; falseOut_valid = ~cond_q.
  - trueOut and falseOut both = data_q; both index outputs = idx_q.
  - fire = (cond_q & trueOut_ready) | (~cond_q & falseOut_ready).
  - fire with an eligible requester: capture the new winner in the same cycle (bypass refill) and stay FULL. Sustained throughput is 1 token/cycle.
  - fire with no eligible requester: go to EMPTY.
  - No fire: hold the registers; all requester ready outputs = 0.
- Latency: 1 cycle from requester handshake to output valid.
- Ready on the non-selected output is ignored.
- Valid stability: once output valid rises, data, index and direction stay constant until fire.
- Requester rule: a requester with only one of its two channels valid is never granted. Its ready stays 0, so no partial consumption is possible.
- Simultaneous requests: exactly one grant per cycle. ready is never asserted to more than one requester.
- rr_ptr wrap: when w = NUM_REQ-1, rr_ptr goes to 0.
- Reset mid-operation: the buffered token is discarded and valid drops immediately (asynchronous).
- No combinational path from trueOut_ready/falseOut_ready to ins_ready in EMPTY. The FULL-state refill path through fire is intended.

Optional Feature:
- Macro: COND_BR_RR_STATS_EN.
- Defined:
  - Adds outputs true_count (32-bit) and false_count (32-bit).
  - Each increments by 1 on a true/false fire respectively, wraps at 2^32, and resets to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cond_br_rr_pkg:
  - state enum {EMPTY, FULL}
  - constant CNT_W = 32
  - function clog2_min1, returning at least 1 for NUM_REQ = 2
- Sub-module rr_pick:
  - Combinational round-robin selector with inputs elig and rr_ptr; outputs any and w.
  - Instantiated once.

Test Plan:
- Reset, then drive requester 2 (ins=0xA5, cond=1) -> ins_ready[2] and conds_ready[2] pulse for 1 cycle; next cycle trueOut_valid=1, trueOut=0xA5, trueOut_index=2, falseOut_valid=0.
- All 4 requesters eligible continuously with both outputs ready -> grant order 0,1,2,3,0; one token per cycle; no two readys high in the same cycle.
- Requester 1 has ins_valid=1, conds_valid=0 for 10 cycles -> never granted; ins_ready[1]=0 throughout; the buffer stays EMPTY.
- FULL with cond=0 and falseOut_ready=0 for 5 cycles while requester 3 is eligible -> falseOut, its index and falseOut_valid stay stable; ins_ready[3]=0. Raising falseOut_ready -> fire and refill with requester 3 in the same cycle.
- Assert rst while FULL -> trueOut_valid/falseOut_valid drop before the next clk edge; after release, rr_ptr=0 (a request from 0 and 3 grants 0).
- With COND_BR_RR_STATS_EN: 3 true fires and 2 false fires -> true_count=3, false_count=2. Preload at 0xFFFFFFFF plus one true fire -> true_count=0.
